sysid_uptime: RTL

Parametrised system-identification peripheral for the NIOS Qsys system. It extends the constant ID slave with:
- a registered read path with fixed 1-cycle latency;
- a build timestamp word;
- a 64-bit free-running uptime counter behind a programmable prescaler, read coherently through a shadow latch;
- a writable scratch word for bus sanity checks.

Software uses it to confirm the hardware build and to measure elapsed time.

---
 rtl/sysid_uptime_if.sv | 28 ++
 rtl/sysid_uptime.sv | 109 ++++++++++
 2 files changed

// File: rtl/sysid_uptime_if.sv
// Bus bundle for the system-ID / uptime slave: word address, strobes, write data,
// registered read data and its valid flag.
interface sysid_uptime_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address,
    output read,
    output write,
    output writedata,
    input  readdata,
    input  readdatavalid
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  writedata,
    output readdata,
    output readdatavalid
  );
endinterface

// File: rtl/sysid_uptime.sv
// System-ID peripheral: constant ID and build timestamp, prescaled 64-bit uptime counter
// with a coherent high-word shadow, a scratch word and a small control register.
module sysid_uptime #(
  parameter logic [31:0] SYSTEM_ID   = 32'h56FA_5E92,
  parameter logic [31:0] TIMESTAMP   = 32'h0,
  parameter int unsigned PRESCALE    = 1,
  parameter logic [31:0] SCRATCH_RST = 32'h0
) (
  input logic            clock,
  input logic            reset_n,
  sysid_uptime_if.slave  bus
);

  localparam logic [2:0]  AddrSysId   = 3'd0;
  localparam logic [2:0]  AddrStamp   = 3'd1;
  localparam logic [2:0]  AddrUpLo    = 3'd2;
  localparam logic [2:0]  AddrUpHi    = 3'd3;
  localparam logic [2:0]  AddrScratch = 3'd4;
  localparam logic [2:0]  AddrCtrl    = 3'd5;
  localparam logic [15:0] PcntMax     = 16'(PRESCALE - 1);

  logic [63:0] cnt_q, cnt_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] scratch_q, scratch_d;
  logic        en_q, en_d;
  logic [31:0] readdata_q, readdata_d;
  logic        rvalid_q, rvalid_d;

  logic        rd_acc;
  logic        wr_scratch;
  logic        wr_ctrl;
  logic        clr;
  logic [31:0] rd_mux;

  // A simultaneous read and write is treated as a write only.
  assign rd_acc     = bus.read & ~bus.write;
  assign wr_scratch = bus.write & (bus.address == AddrScratch);
  assign wr_ctrl    = bus.write & (bus.address == AddrCtrl);
  assign clr        = wr_ctrl & bus.writedata[1];

  always_comb begin
    rd_mux = 32'h0;
    case (bus.address)
      AddrSysId:   rd_mux = SYSTEM_ID;
      AddrStamp:   rd_mux = TIMESTAMP;
      AddrUpLo:    rd_mux = cnt_q[31:0];
      AddrUpHi:    rd_mux = shadow_q;
      AddrScratch: rd_mux = scratch_q;
      AddrCtrl:    rd_mux = {31'h0, en_q};
      default:     rd_mux = 32'h0;
    endcase
  end

  // Counter, prescaler and shadow; a clear outranks both increment and shadow capture.
  always_comb begin
    cnt_d    = cnt_q;
    pcnt_d   = pcnt_q;
    shadow_d = shadow_q;
    if (clr) begin
      cnt_d    = 64'h0;
      pcnt_d   = 16'h0;
      shadow_d = 32'h0;
    end else begin
      if (en_q) begin
        if (pcnt_q == PcntMax) begin
          pcnt_d = 16'h0;
          cnt_d  = cnt_q + 64'd1;
        end else begin
          pcnt_d = pcnt_q + 16'd1;
        end
      end
      if (rd_acc && (bus.address == AddrUpLo)) begin
        shadow_d = cnt_q[63:32];
      end
    end
  end

  always_comb begin
    scratch_d  = wr_scratch ? bus.writedata : scratch_q;
    en_d       = wr_ctrl ? bus.writedata[0] : en_q;
    readdata_d = rd_acc ? rd_mux : readdata_q;
    rvalid_d   = rd_acc;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= 64'h0;
      pcnt_q     <= 16'h0;
      shadow_q   <= 32'h0;
      scratch_q  <= SCRATCH_RST;
      en_q       <= 1'b1;
      readdata_q <= 32'h0;
      rvalid_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pcnt_q     <= pcnt_d;
      shadow_q   <= shadow_d;
      scratch_q  <= scratch_d;
      en_q       <= en_d;
      readdata_q <= readdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign bus.readdata      = readdata_q;
  assign bus.readdatavalid = rvalid_q;

endmodule
